// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline stage: default widths,
// control-bit positions and payload word positions.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NDATA_DEF  = 2;
    localparam int CTRL_W_DEF = 3;
    localparam int CNT_W_DEF  = 16;

    // Control bit positions
    localparam int CTRL_MEMRD = 0;
    localparam int CTRL_MEMWR = 1;
    localparam int CTRL_ZERO  = 2;

    // Payload word positions
    localparam int WORD_ALU = 0;
    localparam int WORD_RS2 = 1;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload, control bits and valid flag.
// Ports: clk/reset, clr_i (drop entry), load_i with valid_i/data_i/ctrl_i,
// and the held entry on valid_o/data_o/ctrl_o.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NDATA  = NDATA_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic                    valid_i,
    input  logic [NDATA*DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0]       ctrl_i,
    output logic                    valid_o,
    output logic [NDATA*DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0]       ctrl_o
);

    logic                    valid_q;
    logic [NDATA*DATA_W-1:0] data_q;
    logic [CTRL_W-1:0]       ctrl_q;

    // Clear drops valid and control only; the payload may stay stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            ctrl_q  <= valid_i ? ctrl_i : '0;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer, flush, freeze and
// a saturating back-pressure counter. Ports: clk, reset, write, flush,
// in_valid/in_ready/in_data/in_ctrl, out_valid/out_ready/out_data/out_ctrl,
// stall_cnt.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NDATA  = NDATA_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NDATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]       in_ctrl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic                    main_v, skid_v;
    logic [NDATA*DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0]       main_ctrl, skid_ctrl;

    logic                    acc, drn, main_upd;
    logic                    main_load, main_vin;
    logic [NDATA*DATA_W-1:0] main_din;
    logic [CTRL_W-1:0]       main_cin;
    logic                    skid_load, skid_vin;

    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // in_ready depends only on registered state and reset.
    assign in_ready = !skid_v && !reset;
    assign acc      = in_valid && in_ready && write && !flush;
    assign drn      = main_v && out_ready && write;
    assign main_upd = write && (!main_v || drn);

    always_comb begin
        main_load = 1'b0;
        main_vin  = 1'b0;
        main_din  = in_data;
        main_cin  = in_ctrl;
        skid_load = 1'b0;
        skid_vin  = 1'b0;
        if (main_upd) begin
            main_load = 1'b1;
            if (skid_v) begin
                // Oldest entry lives in skid; it moves forward first.
                main_vin  = 1'b1;
                main_din  = skid_data;
                main_cin  = skid_ctrl;
                skid_load = 1'b1;
                skid_vin  = acc;
            end else begin
                main_vin = acc;
            end
        end else if (acc) begin
            skid_load = 1'b1;
            skid_vin  = 1'b1;
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .NDATA  (NDATA),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .load_i  (main_load),
        .valid_i (main_vin),
        .data_i  (main_din),
        .ctrl_i  (main_cin),
        .valid_o (main_v),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl)
    );

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .NDATA  (NDATA),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .load_i  (skid_load),
        .valid_i (skid_vin),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .valid_o (skid_v),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (write && main_v && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid, plus a saturation
// sequence on a narrow-counter build and a 3x16 payload build.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, write, flush, in_valid, out_ready;
    logic [2:0]  in_ctrl;
    logic [63:0] in_data;
    logic [47:0] in_data3;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [2:0]  out_ctrl;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [63:0] out_data2;
    logic [2:0]  out_ctrl2;
    logic [1:0]  stall_cnt2;

    logic        in_ready3, out_valid3;
    logic [47:0] out_data3;
    logic [2:0]  out_ctrl3;
    logic [15:0] stall_cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .write(write), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .write(write), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_ctrl(out_ctrl2),
        .stall_cnt(stall_cnt2)
    );

    pipe_stage_skid #(.NDATA(3), .DATA_W(16)) dut3 (
        .clk(clk), .reset(reset), .write(write), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data3), .in_ctrl(in_ctrl),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_ctrl(out_ctrl3),
        .stall_cnt(stall_cnt3)
    );

    // Tag 0 means all-zero payload; tag t gives words {t, t+1}.
    function automatic logic [63:0] mk(input int t);
        logic [63:0] d;
        d = '0;
        if (t != 0) begin
            d[WORD_RS2*32 +: 32] = 32'(t);
            d[WORD_ALU*32 +: 32] = 32'(t + 1);
        end
        return d;
    endfunction

    function automatic logic [47:0] mk3(input int t);
        logic [47:0] d;
        d = '0;
        if (t != 0) begin
            d[0  +: 16] = 16'(t + 2);
            d[16 +: 16] = 16'(t + 1);
            d[32 +: 16] = 16'(t);
        end
        return d;
    endfunction

    typedef struct {
        bit       rst, wr, fl, iv, ordy;
        int       tag;
        bit [2:0] ctrl;
        bit       ev, er;
        int       etag;   // -1: payload not checked
        bit [2:0] ectrl;
        int       ecnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit rst, wr, fl, iv, ordy,
                                input int tag, input bit [2:0] ctrl,
                                input bit ev, er, input int etag,
                                input bit [2:0] ectrl, input int ecnt);
        vec_t v;
        v.rst = rst; v.wr = wr; v.fl = fl; v.iv = iv; v.ordy = ordy;
        v.tag = tag; v.ctrl = ctrl; v.ev = ev; v.er = er;
        v.etag = etag; v.ectrl = ectrl; v.ecnt = ecnt;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset     = v.rst;
        write     = v.wr;
        flush     = v.fl;
        in_valid  = v.iv;
        out_ready = v.ordy;
        in_ctrl   = v.ctrl;
        in_data   = mk(v.tag);
        in_data3  = mk3(v.tag);
    endtask

    initial begin
        // rst wr fl iv or tag ctrl | ev er etag ectrl ecnt
        // reset state
        add(1,1,0,0,0, 0,3'd0, 0,0, 0,3'd0,0);
        // streaming at full rate
        for (int t = 1; t <= 8; t++) begin
            add(0,1,0,1,1, t,3'b011, t>1,1, t-1,(t>1)?3'b011:3'b000,0);
        end
        add(0,1,0,0,1, 0,3'd0, 1,1, 8,3'b011,0);
        add(0,1,0,0,1, 0,3'd0, 0,1,-1,3'b000,0);
        // back-pressure with A,B,C offered
        add(0,1,0,1,0,10,3'b001, 0,1,-1,3'b000,0);
        add(0,1,0,1,0,11,3'b010, 1,1,10,3'b001,0);
        add(0,1,0,1,0,12,3'b100, 1,0,10,3'b001,1);
        add(0,1,0,1,1,12,3'b100, 1,0,10,3'b001,2);
        add(0,1,0,1,1,12,3'b100, 1,1,11,3'b010,2);
        add(0,1,0,0,1, 0,3'd0,   1,1,12,3'b100,2);
        add(0,1,0,0,1, 0,3'd0,   0,1,-1,3'b000,2);
        // reset, then 5 stall cycles
        add(1,1,0,0,0, 0,3'd0,   0,0,-1,3'b000,2);
        add(0,1,0,1,0,20,3'b011, 0,1, 0,3'b000,0);
        for (int k = 0; k < 5; k++) begin
            add(0,1,0,0,0, 0,3'd0, 1,1,20,3'b011,k);
        end
        add(0,1,0,0,1, 0,3'd0,   1,1,20,3'b011,5);
        add(0,1,0,0,1, 0,3'd0,   0,1,-1,3'b000,5);
        // flush with main+skid full, then flush with stage ready
        add(0,1,0,1,0,30,3'b001, 0,1,-1,3'b000,5);
        add(0,1,0,1,0,31,3'b001, 1,1,30,3'b001,5);
        add(0,1,1,1,0,32,3'b010, 1,0,30,3'b001,6);
        add(0,1,0,0,1, 0,3'd0,   0,1,-1,3'b000,7);
        add(0,1,1,1,1,33,3'b010, 0,1,-1,3'b000,7);
        add(0,1,0,0,1, 0,3'd0,   0,1,-1,3'b000,7);
        // freeze mid-stream
        add(0,1,0,1,1,40,3'b011, 0,1,-1,3'b000,7);
        add(0,0,0,1,1,41,3'b011, 1,1,40,3'b011,7);
        add(0,0,0,1,0,41,3'b011, 1,1,40,3'b011,7);
        add(0,0,0,1,1,41,3'b011, 1,1,40,3'b011,7);
        add(0,0,0,1,1,41,3'b011, 1,1,40,3'b011,7);
        add(0,1,0,1,1,41,3'b011, 1,1,40,3'b011,7);
        add(0,1,0,1,1,42,3'b011, 1,1,41,3'b011,7);
        add(0,1,0,0,1, 0,3'd0,   1,1,42,3'b011,7);
        add(0,1,0,0,1, 0,3'd0,   0,1,-1,3'b000,7);
        // reset + flush with two entries buffered
        add(0,1,0,1,0,50,3'b010, 0,1,-1,3'b000,7);
        add(0,1,0,1,0,51,3'b010, 1,1,50,3'b010,7);
        add(1,1,1,1,0,52,3'b010, 1,0,50,3'b010,8);
        add(0,1,0,0,0, 0,3'd0,   0,1, 0,3'b000,0);

        // one reset edge so state is defined before the first row
        drive(vq[0]);
        @(posedge clk); #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge clk);
            chk("out_valid", i, 64'(out_valid), 64'(vq[i].ev));
            chk("in_ready",  i, 64'(in_ready),  64'(vq[i].er));
            chk("out_ctrl",  i, 64'(out_ctrl),  64'(vq[i].ectrl));
            chk("stall_cnt", i, 64'(stall_cnt), 64'(vq[i].ecnt));
            chk("w3_valid",  i, 64'(out_valid3), 64'(vq[i].ev));
            chk("w3_ctrl",   i, 64'(out_ctrl3),  64'(vq[i].ectrl));
            if (vq[i].etag >= 0) begin
                chk("out_data", i, out_data, mk(vq[i].etag));
                chk("w3_data",  i, 64'(out_data3), 64'(mk3(vq[i].etag)));
            end
            @(posedge clk); #1;
        end

        // counter saturation: 10 stall cycles
        reset = 1'b1; write = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b1;
        in_data = mk(60); in_data3 = mk3(60); in_ctrl = 3'b001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("sat_cnt2", 100, 64'(stall_cnt2), 64'd3);
        chk("sat_cnt16", 100, 64'(stall_cnt), 64'd10);
        chk("sat_valid", 100, 64'(out_valid2), 64'd1);
        chk("sat_data", 100, out_data2, mk(60));
        chk("sat_ctrl", 100, 64'(out_ctrl2), 64'(3'b001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
